// File: rtl/sid_env_pkg.sv
// Shared types and constants for the SID-style envelope bank.
// Exponent thresholds are only consumed when SID_ENV_EXP_EN is defined.
package sid_env_pkg;

  typedef enum logic [1:0] {
    ATTACK        = 2'd0,
    DECAY_SUSTAIN = 2'd1,
    RELEASE       = 2'd2
  } env_state_e;

  // Rate periods in ce ticks, indexed by the 4-bit rate nibble
  localparam int unsigned RATE_PERIOD [16] = '{
    9, 32, 63, 95, 149, 220, 267, 313,
    392, 977, 1954, 3126, 3907, 11720, 19532, 31251
  };

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_AD   = 2'd1;
  localparam logic [1:0] REG_SR   = 2'd2;
  localparam logic [1:0] REG_ENV  = 2'd3;

  localparam int unsigned EXP_W = 5;

  localparam logic [7:0] EXP_THR_1 = 8'd94;
  localparam logic [7:0] EXP_THR_2 = 8'd55;
  localparam logic [7:0] EXP_THR_4 = 8'd27;
  localparam logic [7:0] EXP_THR_8 = 8'd15;
  localparam logic [7:0] EXP_THR_16 = 8'd7;

  localparam logic [EXP_W-1:0] EXP_DIV_1  = 5'd1;
  localparam logic [EXP_W-1:0] EXP_DIV_2  = 5'd2;
  localparam logic [EXP_W-1:0] EXP_DIV_4  = 5'd4;
  localparam logic [EXP_W-1:0] EXP_DIV_8  = 5'd8;
  localparam logic [EXP_W-1:0] EXP_DIV_16 = 5'd16;
  localparam logic [EXP_W-1:0] EXP_DIV_30 = 5'd30;

  // Number of rate matches per applied step for a given envelope level
  function automatic logic [EXP_W-1:0] exp_div(input logic [7:0] env);
    if (env >= EXP_THR_1)       return EXP_DIV_1;
    else if (env >= EXP_THR_2)  return EXP_DIV_2;
    else if (env >= EXP_THR_4)  return EXP_DIV_4;
    else if (env >= EXP_THR_8)  return EXP_DIV_8;
    else if (env >= EXP_THR_16) return EXP_DIV_16;
    else                        return EXP_DIV_30;
  endfunction

endpackage

// File: rtl/sid_env_bank_if.sv
// Register bus and flattened envelope output of the envelope bank.
interface sid_env_bank_if #(
  parameter int unsigned VOICES = 3
);
  localparam int unsigned ADDR_W = $clog2(VOICES * 4);

  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [7:0]            data_in;
  logic [7:0]            data_out;
  logic [VOICES*8-1:0]   env_out;

  modport master (output we, addr, data_in, input data_out, env_out);
  modport slave  (input we, addr, data_in, output data_out, env_out);
endinterface

// File: rtl/sid_env_channel.sv
// One ADSR envelope: gate-edge state machine, rate counter and envelope level.
// SID_ENV_EXP_EN adds the exponential decay/release divider.
module sid_env_channel
  import sid_env_pkg::*;
#(
  parameter int unsigned RATE_W = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       gate,
  input  logic [3:0] attack_rate,
  input  logic [3:0] decay_rate,
  input  logic [3:0] sustain_lvl,
  input  logic [3:0] release_rate,
  output logic [7:0] env
);

  env_state_e        state, state_eff, state_nxt;
  logic              gate_q;
  logic              gate_rise, gate_fall;
  logic [RATE_W-1:0] rate_cnt, rate_cnt_nxt;
  logic [3:0]        rate_sel;
  logic              rate_match;
  logic              exp_ok;
  logic [7:0]        env_nxt;

  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & gate_q;

  // Gate edges override the stored state before the step is evaluated
  assign state_eff = gate_rise ? ATTACK : (gate_fall ? RELEASE : state);

  always_ff @(posedge clk) begin
    if (reset)   state <= RELEASE;
    else if (ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state_eff;
    if (state_eff == ATTACK && env_nxt == 8'hFF) state_nxt = DECAY_SUSTAIN;
  end

  always_comb begin
    rate_sel = release_rate;
    env_nxt  = env;
    case (state_eff)
      ATTACK:        rate_sel = attack_rate;
      DECAY_SUSTAIN: rate_sel = decay_rate;
      default:       rate_sel = release_rate;
    endcase
    // Counter only clears on an exact match; a lowered rate lets it wrap
    rate_match   = (rate_cnt == RATE_W'(RATE_PERIOD[rate_sel] - 1));
    rate_cnt_nxt = rate_match ? '0 : rate_cnt + RATE_W'(1);
    if (rate_match) begin
      case (state_eff)
        ATTACK:        if (env != 8'hFF) env_nxt = env + 8'd1;
        DECAY_SUSTAIN: if (exp_ok && env > {sustain_lvl, sustain_lvl}) env_nxt = env - 8'd1;
        default:       if (exp_ok && env != 8'h00) env_nxt = env - 8'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      env      <= 8'h00;
      rate_cnt <= '0;
      gate_q   <= 1'b0;
    end else if (ce) begin
      env      <= env_nxt;
      rate_cnt <= rate_cnt_nxt;
      gate_q   <= gate;
    end
  end

`ifdef SID_ENV_EXP_EN
  logic [EXP_W-1:0] exp_cnt;

  assign exp_ok = (exp_cnt == EXP_W'(exp_div(env) - EXP_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_cnt <= '0;
    end else if (ce) begin
      if (state_eff == ATTACK)  exp_cnt <= '0;
      else if (rate_match)      exp_cnt <= exp_ok ? '0 : exp_cnt + EXP_W'(1);
    end
  end
`else
  assign exp_ok = 1'b1;
`endif

endmodule

// File: rtl/sid_env_bank.sv
// Bank of VOICES envelope generators with SID-like byte registers.
// Define SID_ENV_EXP_EN for exponential decay/release.
module sid_env_bank
  import sid_env_pkg::*;
#(
  parameter int unsigned VOICES = 3,
  parameter int unsigned RATE_W = 15
) (
  input logic           clk,
  input logic           reset,
  input logic           ce_1m,
  sid_env_bank_if.slave bus
);

  localparam int unsigned REGS = VOICES * 4;

  logic [7:0]          ctrl [VOICES];
  logic [7:0]          ad   [VOICES];
  logic [7:0]          sr   [VOICES];
  logic [7:0]          env  [VOICES];
  logic [VOICES*8-1:0] env_flat;
  int unsigned         voice_sel;
  logic [1:0]          reg_sel;
  logic                mapped;
  logic [7:0]          rd_data_c;

  assign voice_sel = 32'(bus.addr) >> 2;
  assign reg_sel   = bus.addr[1:0];
  assign mapped    = (32'(bus.addr) < REGS);

  // Register writes ignore ce_1m; ENV and unmapped addresses drop the write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        ctrl[v] <= 8'h00;
        ad[v]   <= 8'h00;
        sr[v]   <= 8'h00;
      end
    end else if (bus.we && mapped) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        if (voice_sel == v) begin
          case (reg_sel)
            REG_CTRL: ctrl[v] <= bus.data_in;
            REG_AD:   ad[v]   <= bus.data_in;
            REG_SR:   sr[v]   <= bus.data_in;
            default:  ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data_c = 8'h00;
    if (mapped) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        if (voice_sel == v) begin
          case (reg_sel)
            REG_CTRL: rd_data_c = ctrl[v];
            REG_AD:   rd_data_c = ad[v];
            REG_SR:   rd_data_c = sr[v];
            default:  rd_data_c = env[v];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.data_out <= 8'h00;
    else       bus.data_out <= rd_data_c;
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    sid_env_channel #(
      .RATE_W (RATE_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .ce           (ce_1m),
      .gate         (ctrl[v][0]),
      .attack_rate  (ad[v][7:4]),
      .decay_rate   (ad[v][3:0]),
      .sustain_lvl  (sr[v][7:4]),
      .release_rate (sr[v][3:0]),
      .env          (env[v])
    );
  end

  always_comb begin
    env_flat = '0;
    for (int unsigned v = 0; v < VOICES; v++) env_flat[v*8 +: 8] = env[v];
  end

  assign bus.env_out = env_flat;

endmodule

// File: doc/sid_env_bank.md
Name: sid_env_bank

Overview:
- Parametrised bank of SID-style ADSR envelope generators, one per voice; successor to the fixed 3-voice envelope logic inside sid8580.
- Adds a generic voice count, readable per-voice envelope registers and a flattened envelope bus for downstream mixers and DCAs.
- Sits beside the oscillator bank on the 1 MHz clock-enable domain, with a SID-like byte register interface.

Parameters:
- VOICES, 3, number of envelope channels (1..8).
- RATE_W, 15, width of the per-voice rate counter in bits.
- ADDR_W, derived as clog2(VOICES*4), register address width; not overridable.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce_1m  in  1  1 MHz clock enable; envelope timing advances only on cycles where ce_1m=1.
- we  in  1  register write strobe, sampled on the clk rising edge.
- addr  in  ADDR_W  register address.
- data_in  in  8  write data.
- data_out  out  8  registered read data.
- env_out  out  VOICES*8  envelope values; voice v occupies bits [8v+7:8v].

Behaviour:
- Register map, base address v*4 for voice v:
  - +0 CTRL: bit0 is GATE; other bits are stored only.
  - +1 AD: attack rate [7:4], decay rate [3:0].
  - +2 SR: sustain level [7:4], release rate [3:0].
  - +3 ENV: read-only; writes are ignored.
  - Addresses at or above VOICES*4 are unmapped.
- Writes: take effect on the clk edge where we=1, regardless of ce_1m.
- Reads: data_out is registered with 1-cycle latency. CTRL/AD/SR return the stored value; ENV returns the current envelope; unmapped addresses return 0x00.
- Reset: on the next clk edge all registers, envelopes, rate counters, data_out and env_out go to 0; every state goes to RELEASE. Reset mid-envelope aborts immediately.
- Rate period table, in ce ticks, indexed by nibble 0..15: 9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251. Held in the package.
- Rate counter: increments on each ce tick. When counter == period-1 for the current state's rate, the counter clears to 0 and the envelope steps.
  - If the rate is lowered while the counter is already above the new period, the counter runs on and wraps modulo 2^RATE_W (SID-accurate).
- Gate edges: the GATE value at each ce tick is compared with the value at the previous ce tick.
  - 0->1: state becomes ATTACK.
  - 1->0: state becomes RELEASE.
  - The edge is evaluated before the step in the same tick. A write on the same edge as a ce tick is seen at the next ce tick.
- States:
  - ATTACK: each step does env+1. When the result is 0xFF, the state becomes DECAY_SUSTAIN. No overflow.
  - DECAY_SUSTAIN: each step decrements while env > sustain*0x11; holds while env <= that level. Raising the sustain level never raises env.
  - RELEASE: each step decrements down to 0x00, then holds. No wrap.
- env_out: driven directly from the envelope registers (no extra latency after a step).

Optional Feature:
- Macro SID_ENV_EXP_EN.
- Defined: in DECAY_SUSTAIN and RELEASE, a step is applied only every Nth rate match. A per-voice exponent counter supplies N:
  - env > 93: N=1
  - env 55..93: N=2
  - env 27..54: N=4
  - env 15..26: N=8
  - env 7..14: N=16
  - env 0..6: N=30
  - ATTACK is always N=1.
  - The exponent counter clears on every applied step and on entry to ATTACK.
- Undefined: every rate match steps (linear); no exponent counter is synthesised.

Decomposition:
- Package sid_env_pkg holds:
  - the state enum (ATTACK, DECAY_SUSTAIN, RELEASE);
  - the 16-entry rate period table as constants;
  - the exponent thresholds and divisors;
  - register offset constants (CTRL=0, AD=1, SR=2, ENV=3).
- Sub-module sid_env_channel: one envelope (state machine, rate counter, optional exponent counter), generated VOICES times.
- Top level keeps register storage, address decode and read mux.

Test Plan (ce_1m tied high unless stated):
- Reset pulse mid-attack -> next cycle every env_out byte is 0x00, data_out is 0x00, and a read of ENV returns 0x00.
- Voice 0: AD=0x00, SR=0xF0, CTRL=0x01 -> env increments every 9 ticks, reaches 0xFF after 2295 ticks, then holds at 0xFF.
- Voice 0: AD=0x00, SR=0x80, gate on, linear build -> after reaching 0xFF, decays to 0x88 in 119 steps of 9 ticks, then holds.
- Then CTRL=0x00 with release 0 -> env reaches 0x00 and holds; no wrap to 0xFF.
- With VOICES=4, gate voice 3 only (CTRL at 0x0C) -> voices 0-2 stay at 0x00. Read at addr 0x0F returns voice 3's env one cycle later; read at 0x10+ (if ADDR_W allows) returns 0x00.
- ce_1m held low for 500 cycles during attack -> env frozen, AD write still readable back. Resuming ce continues from the frozen value.
- SID_ENV_EXP_EN build: decay from 0xFF to 0x00 at rate 0 takes more ticks than the linear build. Steps below env 7 occur every 270 ticks.
